// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full-adder cell used as the serial adder's bit slice.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single cell.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise it is tied to 0.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] a_p0, b_p0, res_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             carry_p0, cout_p0;
  logic             sum_bit, cell_cout, last_bit, accept;

  adder_1bit u_cell (
    .a    (a_p0[0]),
    .b    (b_p0[0]),
    .cin  (carry_p0),
    .sum  (sum_bit),
    .cout (cell_cout)
  );

  assign last_bit = (state_p0 == RUN) && (cnt_p0 == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state_p0;
    accept    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        // A start seen in DONE chains straight into the next operation.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // Operand/result shift stage: subtraction is a + ~b + 1, the +1 entering as carry-in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0     <= '0;
      b_p0     <= '0;
      res_p0   <= '0;
      cnt_p0   <= '0;
      carry_p0 <= 1'b0;
      cout_p0  <= 1'b0;
    end else if (accept) begin
      a_p0     <= a;
      b_p0     <= sub ? ~b : b;
      carry_p0 <= sub;
      cnt_p0   <= '0;
    end else if (state_p0 == RUN) begin
      a_p0     <= a_p0 >> 1;
      b_p0     <= b_p0 >> 1;
      res_p0   <= {sum_bit, res_p0[WIDTH-1:1]};
      carry_p0 <= cell_cout;
      cnt_p0   <= cnt_p0 + CNT_W'(1);
      if (last_bit) cout_p0 <= cell_cout;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_p0;

  // On the MSB cycle carry_p0 is the carry into the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ovf_p0 <= 1'b0;
    else if (last_bit) ovf_p0 <= carry_p0 ^ cell_cout;
  end

  assign overflow = ovf_p0;
`else
  assign overflow = 1'b0;
`endif

  assign busy   = (state_p0 == RUN);
  assign done   = (state_p0 == DONE);
  assign result = res_p0;
  assign cout   = cout_p0;

endmodule
